// File: rtl/i2s_rx_sync_pkg.sv
// Shared definitions for the I2S ADC-path receiver: default sample width and channel encoding.
package i2s_rx_sync_pkg;

    localparam int BITSIZE_DEF = 16;

    typedef enum logic {
        CH_LEFT  = 1'b0,
        CH_RIGHT = 1'b1
    } chan_e;

endpackage

// File: rtl/i2s_pin_sync.sv
// Multi-stage synchroniser for one asynchronous I2S pin into the clk domain.
module i2s_pin_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], din};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign dout = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/i2s_rx_sync.sv
// I2S (Philips) receiver: oversamples BCLK/LRCLK/SDATA, deserialises left/right words and
// presents each stereo pair on a valid/ready interface with overrun and short-slot flags.
module i2s_rx_sync
    import i2s_rx_sync_pkg::*;
#(
    parameter int BITSIZE     = BITSIZE_DEF,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               bclk,
    input  logic               lrclk,
    input  logic               sdata,
    output logic [BITSIZE-1:0] left_chan,
    output logic [BITSIZE-1:0] right_chan,
    output logic               valid,
    input  logic               ready,
    output logic               overrun,
    output logic               frame_err
);

    localparam int CW = $clog2(BITSIZE + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(BITSIZE);

    logic bclk_s;
    logic lrclk_s;
    logic sdata_s;

    // All three pins use identical chains so they stay mutually aligned after synchronisation.
    i2s_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_bclk (
        .clk (clk),
        .rst (rst),
        .din (bclk),
        .dout(bclk_s)
    );

    i2s_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_lrclk (
        .clk (clk),
        .rst (rst),
        .din (lrclk),
        .dout(lrclk_s)
    );

    i2s_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sdata (
        .clk (clk),
        .rst (rst),
        .din (sdata),
        .dout(sdata_s)
    );

    logic               bclk_d_q,     bclk_d_d;
    chan_e              lr_prev_q,    lr_prev_d;
    logic [CW-1:0]      cnt_q,        cnt_d;
    logic [BITSIZE-1:0] shreg_q,      shreg_d;
    logic               locked_q,     locked_d;
    logic               left_ok_q,    left_ok_d;
    logic [BITSIZE-1:0] left_hold_q,  left_hold_d;
    logic [BITSIZE-1:0] left_chan_q,  left_chan_d;
    logic [BITSIZE-1:0] right_chan_q, right_chan_d;
    logic               valid_q,      valid_d;
    logic               overrun_q,    overrun_d;
    logic               frame_err_q,  frame_err_d;

    logic               rise;
    logic               boundary;
    logic               load;
    logic [CW-1:0]      cnt_next;
    logic [BITSIZE-1:0] sh_next;
    logic [BITSIZE-1:0] word;

    always_comb begin
        bclk_d_d     = bclk_s;
        lr_prev_d    = lr_prev_q;
        cnt_d        = cnt_q;
        shreg_d      = shreg_q;
        locked_d     = locked_q;
        left_ok_d    = left_ok_q;
        left_hold_d  = left_hold_q;
        left_chan_d  = left_chan_q;
        right_chan_d = right_chan_q;
        valid_d      = valid_q;
        overrun_d    = 1'b0;
        frame_err_d  = 1'b0;
        load         = 1'b0;

        rise     = bclk_s & ~bclk_d_q;
        boundary = rise & (lrclk_s != lr_prev_q);

        sh_next  = shreg_q;
        cnt_next = cnt_q;
        if (rise && (cnt_q < CNT_MAX)) begin
            sh_next  = {shreg_q[BITSIZE-2:0], sdata_s};
            cnt_next = cnt_q + 1'b1;
        end
        // Left-justify so a short slot keeps its MSBs in place with zero-filled LSBs.
        word = sh_next << (CNT_MAX - cnt_next);

        if (rise) begin
            lr_prev_d = chan_e'(lrclk_s);
            shreg_d   = sh_next;
            cnt_d     = cnt_next;
        end

        if (boundary) begin
            cnt_d    = '0;
            shreg_d  = '0;
            locked_d = 1'b1;
            if (locked_q) begin
                if (lr_prev_q == CH_LEFT) begin
                    left_hold_d = word;
                    left_ok_d   = 1'b1;
                    frame_err_d = (cnt_next < CNT_MAX);
                end else if (left_ok_q) begin
                    load        = 1'b1;
                    frame_err_d = (cnt_next < CNT_MAX);
                end
            end
        end

        if (load) begin
            left_chan_d  = left_hold_q;
            right_chan_d = word;
            valid_d      = 1'b1;
            overrun_d    = valid_q & ~ready;
        end else if (valid_q && ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bclk_d_q     <= 1'b0;
            lr_prev_q    <= CH_LEFT;
            cnt_q        <= '0;
            shreg_q      <= '0;
            locked_q     <= 1'b0;
            left_ok_q    <= 1'b0;
            left_hold_q  <= '0;
            left_chan_q  <= '0;
            right_chan_q <= '0;
            valid_q      <= 1'b0;
            overrun_q    <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            bclk_d_q     <= bclk_d_d;
            lr_prev_q    <= lr_prev_d;
            cnt_q        <= cnt_d;
            shreg_q      <= shreg_d;
            locked_q     <= locked_d;
            left_ok_q    <= left_ok_d;
            left_hold_q  <= left_hold_d;
            left_chan_q  <= left_chan_d;
            right_chan_q <= right_chan_d;
            valid_q      <= valid_d;
            overrun_q    <= overrun_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign left_chan  = left_chan_q;
    assign right_chan = right_chan_q;
    assign valid      = valid_q;
    assign overrun    = overrun_q;
    assign frame_err  = frame_err_q;

endmodule
